fp_mul_booth_seq: RTL

FP_MUL_BOOTH_SEQ -- requirements
Module: fp_mul_booth_seq

---
 rtl/fp_pkg.sv | 21 ++
 rtl/booth_r4_digit.sv | 17 +
 rtl/fp_mul_booth_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision Booth multiplier.
package fp_pkg;

    localparam int unsigned EXP_BIAS     = 127;
    localparam int unsigned EXP_W        = 8;
    localparam int unsigned FRC_W        = 23;
    localparam int unsigned BOOTH_DIGITS = 13;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Unbiased sum eX + eY - bias, two's complement, two guard bits wide.
    function automatic logic [EXP_W+1:0] exp_add(input logic [EXP_W-1:0] a,
                                                 input logic [EXP_W-1:0] b);
        return {2'b00, a} + {2'b00, b} - (EXP_W + 2)'(EXP_BIAS);
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth digit decode: 3-bit multiplier window to sign/magnitude selects.
module booth_r4_digit (
    input  logic [2:0] i_window,
    output logic       o_neg,
    output logic       o_one,
    output logic       o_two
);

    // Digit value = -2*w[2] + w[1] + w[0]; window 3'b111 is zero, so no negation there.
    always_comb begin
        o_neg = i_window[2] & ~(i_window[1] & i_window[0]);
        o_one = i_window[1] ^ i_window[0];
        o_two = (i_window[2] & ~i_window[1] & ~i_window[0]) |
                (~i_window[2] & i_window[1] & i_window[0]);
    end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth significand multiplier for IEEE-754 single precision.
// Produces the raw 48-bit product, sign and unbiased exponent sum; normalize and
// round live downstream.
module fp_mul_booth_seq
    import fp_pkg::*;
#(
    parameter int unsigned MAN_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          fp_X,
    input  logic [31:0]          fp_Y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*MAN_W-1:0]   frc_Z_full,
    output logic                 sign_Z,
    output logic [EXP_W+1:0]     exp_sum,
    output logic                 flush,
    output logic                 special
);

    localparam int unsigned ACC_W = 2 * MAN_W + 2;   // signed partial sums need headroom
    localparam int unsigned REC_W = MAN_W + 3;       // {2'b00, mant_Y, 1'b0}

    state_t              r_state;
    state_t              w_state_next;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_mcand;
    logic [REC_W-1:0]    r_rec;
    logic [3:0]          r_cnt;
    logic                r_sign;
    logic [EXP_W+1:0]    r_exp;
    logic                r_flush;
    logic                r_special;

    logic [EXP_W-1:0]    w_ex;
    logic [EXP_W-1:0]    w_ey;
    logic                w_special;
    logic                w_flush;
    logic                w_xfer;
    logic                w_last;
    logic                w_neg;
    logic                w_one;
    logic                w_two;
    logic [ACC_W-1:0]    w_mag;
    logic [ACC_W-1:0]    w_acc_next;
    logic [1:0]          w_unused_acc_msb;

    assign w_ex      = fp_X[30:23];
    assign w_ey      = fp_Y[30:23];
    assign w_special = (w_ex == 8'hFF) | (w_ey == 8'hFF);
    assign w_flush   = ~w_special & ((w_ex == 8'h00) | (w_ey == 8'h00));
    assign w_xfer    = in_valid & (r_state == IDLE);
    assign w_last    = (r_cnt == 4'(BOOTH_DIGITS - 1));

    // The recoder window always sits in the low bits; r_rec shifts right by one digit per cycle.
    booth_r4_digit u_digit (
        .i_window (r_rec[2:0]),
        .o_neg    (w_neg),
        .o_one    (w_one),
        .o_two    (w_two)
    );

    // Partial product select and accumulate; r_mcand already carries the 2*i shift.
    always_comb begin
        w_mag = '0;
        if (w_two) begin
            w_mag = {r_mcand[ACC_W-2:0], 1'b0};
        end else if (w_one) begin
            w_mag = r_mcand;
        end
        w_acc_next = w_neg ? (r_acc - w_mag) : (r_acc + w_mag);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; in_ready depends only on state, never on out_ready.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_xfer) begin
                    w_state_next = (w_flush | w_special) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture on transfer, one Booth digit per CALC cycle; held untouched in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_rec     <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_flush   <= 1'b0;
            r_special <= 1'b0;
        end else if (w_xfer) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_mcand   <= {{(ACC_W - MAN_W){1'b0}}, 1'b1, fp_X[FRC_W-1:0]};
            r_rec     <= {2'b00, 1'b1, fp_Y[FRC_W-1:0], 1'b0};
            r_sign    <= fp_X[31] ^ fp_Y[31];
            r_exp     <= exp_add(w_ex, w_ey);
            r_flush   <= w_flush;
            r_special <= w_special;
        end else if (r_state == CALC) begin
            r_acc   <= w_acc_next;
            r_mcand <= {r_mcand[ACC_W-3:0], 2'b00};
            r_rec   <= {2'b00, r_rec[REC_W-1:2]};
            r_cnt   <= r_cnt + 4'd1;
        end
    end

    // The final sum is the non-negative product; the two guard bits end at zero.
    assign w_unused_acc_msb = r_acc[ACC_W-1:ACC_W-2];

    assign frc_Z_full = r_acc[2*MAN_W-1:0];
    assign sign_Z     = r_sign;
    assign exp_sum    = r_exp;
    assign flush      = r_flush;
    assign special    = r_special;

endmodule
